// File: rtl/viterbi_pkg.sv
// Shared constants, FSM encoding and trellis helpers for the K=3 rate-1/2 Viterbi decoder.
package viterbi_pkg;

    localparam int unsigned K          = 3;
    localparam int unsigned NUM_STATES = 1 << (K - 1);

    localparam logic [2:0] G0_DEFAULT = 3'b111;
    localparam logic [2:0] G1_DEFAULT = 3'b101;

    typedef enum logic [1:0] {
        ST_ACS,
        ST_SELECT,
        ST_TRACE,
        ST_DONE
    } fsm_state_e;

    // Coded pair {c1,c0} emitted when input u is applied in state s = {s1,s0}.
    function automatic logic [1:0] expected_pair(input logic u, input logic [1:0] s,
                                                 input logic [2:0] g0, input logic [2:0] g1);
        logic [2:0] reg_bits;
        reg_bits = {u, s};
        return {^(g1 & reg_bits), ^(g0 & reg_bits)};
    endfunction

    function automatic logic [1:0] branch_metric(input logic [1:0] rx, input logic [1:0] exp_pair);
        logic [1:0] diff;
        diff = rx ^ exp_pair;
        return {1'b0, diff[1]} + {1'b0, diff[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs_unit.sv
// Add-compare-select for one next state: saturating adds, tie resolves toward predecessor 0.
module viterbi_acs_unit #(
    parameter int unsigned PM_W = 8
) (
    input  logic [PM_W-1:0] pm0_i,
    input  logic [PM_W-1:0] pm1_i,
    input  logic [1:0]      bm0_i,
    input  logic [1:0]      bm1_i,
    output logic [PM_W-1:0] pm_o,
    output logic            dec_o
);

    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] m0;
    logic [PM_W-1:0] m1;

    always_comb begin
        sum0  = (PM_W+1)'(pm0_i) + (PM_W+1)'(bm0_i);
        sum1  = (PM_W+1)'(pm1_i) + (PM_W+1)'(bm1_i);
        m0    = sum0[PM_W] ? '1 : sum0[PM_W-1:0];
        m1    = sum1[PM_W] ? '1 : sum1[PM_W-1:0];
        dec_o = (m0 > m1);
        pm_o  = dec_o ? m1 : m0;
    end

endmodule

// File: rtl/viterbi_dec_k3.sv
// Frame-based hard-decision Viterbi decoder: ACS per accepted symbol, then traceback and
// a held valid/ready result. Survivor decisions are kept in a T x 4 flop array.
module viterbi_dec_k3
    import viterbi_pkg::*;
#(
    parameter int unsigned FRAME_LEN  = 62,
    parameter logic [2:0]  G0         = G0_DEFAULT,
    parameter logic [2:0]  G1         = G1_DEFAULT,
    parameter int unsigned PM_W       = 8,
    parameter bit          TERMINATED = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           data_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FRAME_LEN-1:0] data_out,
    output logic [PM_W-1:0]      out_metric,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int unsigned       T         = FRAME_LEN + 2;
    localparam int unsigned       STEP_W    = $clog2(T);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T - 1);

    fsm_state_e                  state_q, state_d;
    logic [STEP_W-1:0]           step_q, step_d;
    logic [PM_W-1:0]             pm_q [NUM_STATES];
    logic [PM_W-1:0]             pm_d [NUM_STATES];
    logic [PM_W-1:0]             pm_new [NUM_STATES];
    logic [NUM_STATES-1:0]       dec;
    logic [NUM_STATES-1:0]       surv_q [T];
    logic                        surv_we;
    logic [1:0]                  tstate_q, tstate_d;
    logic [1:0]                  start_state;
    logic [FRAME_LEN-1:0]        data_q, data_d;
    logic [PM_W-1:0]             metric_q, metric_d;

    // Next state n = {u, s1}; its predecessors differ only in the dropped s0 bit.
    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam logic [1:0] NS = 2'(n);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};

        logic [1:0] bm0;
        logic [1:0] bm1;

        always_comb begin
            bm0 = branch_metric(data_in, expected_pair(NS[1], P0, G0, G1));
            bm1 = branch_metric(data_in, expected_pair(NS[1], P1, G0, G1));
        end

        viterbi_acs_unit #(.PM_W(PM_W)) u_acs (
            .pm0_i (pm_q[P0]),
            .pm1_i (pm_q[P1]),
            .bm0_i (bm0),
            .bm1_i (bm1),
            .pm_o  (pm_new[n]),
            .dec_o (dec[n])
        );
    end

    always_comb begin
        start_state = '0;
        if (!TERMINATED) begin
            for (int unsigned i = 1; i < NUM_STATES; i++) begin
                if (pm_q[i] < pm_q[start_state]) start_state = 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        pm_d     = pm_q;
        tstate_d = tstate_q;
        data_d   = data_q;
        metric_d = metric_q;
        surv_we  = 1'b0;
        case (state_q)
            ST_ACS: begin
                if (in_valid) begin
                    surv_we = 1'b1;
                    pm_d    = pm_new;
                    if (step_q == LAST_STEP) state_d = ST_SELECT;
                    else                     step_d  = step_q + STEP_W'(1);
                end
            end
            ST_SELECT: begin
                tstate_d = start_state;
                metric_d = pm_q[start_state];
                step_d   = LAST_STEP;
                state_d  = ST_TRACE;
            end
            ST_TRACE: begin
                // Tail steps (step >= FRAME_LEN) match no index and are dropped.
                for (int unsigned i = 0; i < FRAME_LEN; i++) begin
                    if (step_q == STEP_W'(i)) data_d[i] = tstate_q[1];
                end
                tstate_d = {tstate_q[0], surv_q[step_q][tstate_q]};
                if (step_q == '0) state_d = ST_DONE;
                else              step_d  = step_q - STEP_W'(1);
            end
            ST_DONE: begin
                if (out_ready) begin
                    for (int unsigned i = 0; i < NUM_STATES; i++) pm_d[i] = (i == 0) ? '0 : '1;
                    step_d  = '0;
                    state_d = ST_ACS;
                end
            end
            default: state_d = ST_ACS;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_ACS;
            step_q   <= '0;
            tstate_q <= '0;
            data_q   <= '0;
            metric_q <= '0;
            for (int unsigned i = 0; i < NUM_STATES; i++) pm_q[i] <= (i == 0) ? '0 : '1;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            tstate_q <= tstate_d;
            data_q   <= data_d;
            metric_q <= metric_d;
            pm_q     <= pm_d;
        end
    end

    always_ff @(posedge clk) begin
        if (surv_we) surv_q[step_q] <= dec;
    end

    assign in_ready   = (state_q == ST_ACS);
    assign out_valid  = (state_q == ST_DONE);
    assign busy       = !((state_q == ST_ACS) && (step_q == '0));
    assign data_out   = data_q;
    assign out_metric = metric_q;

endmodule

// File: tb/tb_viterbi_dec_k3.sv
// Scoreboard bench: a 62-bit terminated decoder and an 8-bit unterminated one, checked
// against an encoder plus error bookkeeping and an exhaustive maximum-likelihood search.
module tb_viterbi_dec_k3;

    localparam int unsigned FA = 62;
    localparam int unsigned TA = FA + 2;
    localparam int unsigned FB = 8;
    localparam int unsigned TB = FB + 2;
    localparam logic [2:0]  G0 = 3'b111;
    localparam logic [2:0]  G1 = 3'b101;
    localparam logic [63:0] PAT_FULL = 64'hA5A5_3C3C_0F0F_1234;
    localparam logic [61:0] PAT = 62'(PAT_FULL >> 2);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    a_din = '0, b_din = '0;
    logic          a_vin = 1'b0, b_vin = 1'b0;
    logic          a_rdy, b_rdy;
    logic [FA-1:0] a_dout;
    logic [FB-1:0] b_dout;
    logic [7:0]    a_met, b_met;
    logic          a_vout, b_vout;
    logic          a_oready = 1'b1, b_oready = 1'b0;
    logic          a_busy, b_busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned last_cyc = 0;

    logic [1:0]    sym [64];
    logic [FA-1:0] exp_a_data [$];
    int unsigned   exp_a_met [$];
    int unsigned   exp_b_met [$];
    logic [255:0]  exp_b_ok [$];

    viterbi_dec_k3 #(.FRAME_LEN(FA), .G0(G0), .G1(G1), .PM_W(8), .TERMINATED(1'b1)) dut_a (
        .clk(clk), .reset(rst), .data_in(a_din), .in_valid(a_vin), .in_ready(a_rdy),
        .data_out(a_dout), .out_metric(a_met), .out_valid(a_vout), .out_ready(a_oready), .busy(a_busy)
    );

    viterbi_dec_k3 #(.FRAME_LEN(FB), .G0(G0), .G1(G1), .PM_W(8), .TERMINATED(1'b0)) dut_b (
        .clk(clk), .reset(rst), .data_in(b_din), .in_valid(b_vin), .in_ready(b_rdy),
        .data_out(b_dout), .out_metric(b_met), .out_valid(b_vout), .out_ready(b_oready), .busy(b_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    // Convolutional encoder: info bits first (bit 0 first), then zero tail.
    task automatic encode(input logic [63:0] info, input int unsigned len);
        logic s1, s0, u;
        s1 = 1'b0;
        s0 = 1'b0;
        for (int unsigned i = 0; i < len + 2; i++) begin
            u      = (i < len) ? info[i] : 1'b0;
            sym[i] = {^(G1 & {u, s1, s0}), ^(G0 & {u, s1, s0})};
            s0     = s1;
            s1     = u;
        end
    endtask

    // Hamming distance of a full candidate input sequence (tail included) to the received symbols.
    function automatic int unsigned dist_to_rx(input logic [63:0] cand, input int unsigned steps);
        logic s1, s0, u;
        logic [1:0] c;
        int unsigned d;
        s1 = 1'b0;
        s0 = 1'b0;
        d  = 0;
        for (int unsigned i = 0; i < steps; i++) begin
            u  = cand[i];
            c  = {^(G1 & {u, s1, s0}), ^(G0 & {u, s1, s0})} ^ sym[i];
            d += int'(c[0]) + int'(c[1]);
            s0 = s1;
            s1 = u;
        end
        return d;
    endfunction

    task automatic flip(input int unsigned p);
        sym[p / 2][p % 2] = ~sym[p / 2][p % 2];
    endtask

    // Up to two distinct bit errors: always within the correction radius of this code.
    task automatic add_random_errors(input int unsigned n, input int unsigned nsym);
        int unsigned p1, p2;
        p1 = $urandom_range(2 * nsym - 1);
        p2 = p1;
        if (n >= 1) flip(p1);
        if (n >= 2) begin
            while (p2 == p1) p2 = $urandom_range(2 * nsym - 1);
            flip(p2);
        end
    endtask

    task automatic drive(input bit sel, input int unsigned len, input int unsigned gap);
        int unsigned i, guard;
        logic v;
        bit acc;
        i = 0;
        guard = 0;
        while (i < len && guard < 3000) begin
            v = (gap == 0) || ($urandom_range(99) >= gap);
            if (sel) begin b_vin = v; b_din = v ? sym[i] : 2'($urandom); end
            else     begin a_vin = v; a_din = v ? sym[i] : 2'($urandom); end
            acc = v && (sel ? b_rdy : a_rdy);
            if (acc) last_cyc = cyc;
            @(posedge clk); #1;
            if (acc) i++;
            guard++;
        end
        a_vin = 1'b0;
        b_vin = 1'b0;
        chk(sel ? "b_symbols_accepted" : "a_symbols_accepted", 64'(i), 64'(len));
    endtask

    task automatic wait_valid(input bit sel, input string name);
        int unsigned n;
        n = 0;
        while (!(sel ? b_vout : a_vout) && n < 400) begin @(posedge clk); #1; n++; end
        chk(name, 64'(sel ? b_vout : a_vout), 64'd1);
    endtask

    task automatic wait_release(input bit sel, input string name);
        int unsigned n;
        n = 0;
        while ((sel ? b_vout : a_vout) && n < 60) begin @(posedge clk); #1; n++; end
        chk(name, 64'(sel ? b_rdy : a_rdy), 64'd1);
        chk({name, "_busy"}, 64'(sel ? b_busy : a_busy), 64'd0);
    endtask

    task automatic a_frame(input logic [FA-1:0] info, input int unsigned nerr, input int unsigned gap);
        encode(64'(info), FA);
        add_random_errors(nerr, TA);
        exp_a_data.push_back(info);
        exp_a_met.push_back(nerr);
        drive(1'b0, TA, gap);
        wait_valid(1'b0, "a_valid");
        wait_release(1'b0, "a_release");
    endtask

    always @(negedge clk) begin : mon_a
        logic [FA-1:0] ed;
        int unsigned em;
        if (!rst && a_vout && a_oready) begin
            if (exp_a_data.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_frame: out_valid with no frame pending");
            end else begin
                ed = exp_a_data.pop_front();
                em = exp_a_met.pop_front();
                chk("a_data", 64'(a_dout), 64'(ed));
                chk("a_metric", 64'(a_met), 64'(em));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        logic [255:0] okm;
        int unsigned em;
        if (!rst && b_vout && b_oready) begin
            if (exp_b_met.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_frame: out_valid with no frame pending");
            end else begin
                okm = exp_b_ok.pop_front();
                em  = exp_b_met.pop_front();
                chk("b_data_is_ml", 64'(okm[b_dout]), 64'd1);
                chk("b_metric", 64'(b_met), 64'(em));
            end
        end
    end

    initial begin
        int unsigned lat, nerr, mind, d;
        logic [255:0] okm;
        logic [7:0] binfo;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_in_ready", 64'(a_rdy), 64'd1);
        chk("rst_a_out_valid", 64'(a_vout), 64'd0);
        chk("rst_a_data", 64'(a_dout), 64'd0);
        chk("rst_a_metric", 64'(a_met), 64'd0);
        chk("rst_a_busy", 64'(a_busy), 64'd0);
        chk("rst_b_in_ready", 64'(b_rdy), 64'd1);
        chk("rst_b_out_valid", 64'(b_vout), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Error-free pattern with latency measurement.
        encode(64'(PAT), FA);
        exp_a_data.push_back(PAT);
        exp_a_met.push_back(0);
        drive(1'b0, TA, 0);
        chk("a_in_ready_select", 64'(a_rdy), 64'd0);
        chk("a_busy_select", 64'(a_busy), 64'd1);
        wait_valid(1'b0, "a_valid_clean");
        lat = cyc - last_cyc;
        chk("a_latency", 64'(lat), 64'(TA + 2));
        wait_release(1'b0, "a_release_clean");

        // Single error on c0 of symbol 10.
        encode(64'(PAT), FA);
        sym[10][0] = ~sym[10][0];
        exp_a_data.push_back(PAT);
        exp_a_met.push_back(1);
        drive(1'b0, TA, 0);
        wait_valid(1'b0, "a_valid_err1");
        wait_release(1'b0, "a_release_err1");

        // Two spaced errors on c1 of symbols 5 and 40.
        encode(64'(PAT), FA);
        sym[5][1]  = ~sym[5][1];
        sym[40][1] = ~sym[40][1];
        exp_a_data.push_back(PAT);
        exp_a_met.push_back(2);
        drive(1'b0, TA, 0);
        wait_valid(1'b0, "a_valid_err2");
        wait_release(1'b0, "a_release_err2");

        // Back-pressure: consumer stalls 20 cycles.
        a_oready = 1'b0;
        encode(64'(PAT), FA);
        exp_a_data.push_back(PAT);
        exp_a_met.push_back(0);
        drive(1'b0, TA, 0);
        wait_valid(1'b0, "a_valid_bp");
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("a_bp_hold_data", 64'(a_dout), 64'(PAT));
            chk("a_bp_hold_valid", 64'(a_vout), 64'd1);
            chk("a_bp_in_ready", 64'(a_rdy), 64'd0);
        end
        a_oready = 1'b1;
        wait_release(1'b0, "a_release_bp");
        a_frame({$urandom, $urandom}, $urandom_range(2), 0);

        // Gapped input, 50% idle with garbage on data_in.
        encode(64'(PAT), FA);
        exp_a_data.push_back(PAT);
        exp_a_met.push_back(0);
        drive(1'b0, TA, 50);
        wait_valid(1'b0, "a_valid_gap");
        wait_release(1'b0, "a_release_gap");

        // Reset during traceback aborts the frame.
        encode({$urandom, $urandom}, FA);
        add_random_errors(1, TA);
        exp_a_data.push_back('0);
        exp_a_met.push_back(0);
        drive(1'b0, TA, 0);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("a_midtrace_rst_out_valid", 64'(a_vout), 64'd0);
        chk("a_midtrace_rst_in_ready", 64'(a_rdy), 64'd1);
        chk("a_midtrace_rst_busy", 64'(a_busy), 64'd0);
        chk("a_midtrace_rst_data", 64'(a_dout), 64'd0);
        void'(exp_a_data.pop_back());
        void'(exp_a_met.pop_back());
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        a_frame({$urandom, $urandom}, $urandom_range(2), 0);

        for (int f = 0; f < 4; f++) a_frame({$urandom, $urandom}, $urandom_range(2), $urandom_range(60));

        // Unterminated 8-bit decoder against exhaustive maximum-likelihood search.
        for (int f = 0; f < 12; f++) begin
            binfo = 8'($urandom);
            encode(64'(binfo), FB);
            nerr = $urandom_range(3);
            for (int e = 0; e < int'(nerr); e++) flip($urandom_range(2 * TB - 1));
            mind = 1000;
            okm  = '0;
            for (int c = 0; c < 1024; c++) begin
                d = dist_to_rx(64'(c), TB);
                if (d < mind) begin mind = d; okm = '0; end
                if (d == mind) okm[c & 255] = 1'b1;
            end
            exp_b_met.push_back(mind);
            exp_b_ok.push_back(okm);
            drive(1'b1, TB, $urandom_range(60));
            wait_valid(1'b1, "b_valid");
            repeat ($urandom_range(3)) begin @(posedge clk); #1; end
            b_oready = 1'b1;
            wait_release(1'b1, "b_release");
            b_oready = 1'b0;
        end

        chk("a_frames_all_seen", 64'(exp_a_data.size()), 64'd0);
        chk("b_frames_all_seen", 64'(exp_b_met.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
